// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and default constants for the motor PWM driver.
package motor_pwm_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_FAULT
  } state_e;

  localparam int DEF_CNT_BITS = 8;
  localparam int DEF_STEP     = 4;
  localparam int DEF_DUTY_30  = 77;
  localparam int DEF_DUTY_50  = 128;
  localparam int DEF_DUTY_100 = 256;

endpackage

// File: rtl/motor_pwm_driver_sync2.sv
// Parameterized-width two-flop synchronizer with synchronous active-low reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Converts one-hot speed levels into a slew-limited, period-aligned PWM drive
// with a latched fault on illegal level combinations.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int STEP     = DEF_STEP,
  parameter int DUTY_30  = DEF_DUTY_30,
  parameter int DUTY_50  = DEF_DUTY_50,
  parameter int DUTY_100 = DEF_DUTY_100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              lvl_30,
  input  logic              lvl_50,
  input  logic              lvl_100,
  output logic              pwm_out,
  output logic [CNT_BITS:0] duty,
  output logic              at_target,
  output logic              fault
);

  localparam logic [CNT_BITS:0]   STEP_W  = STEP[CNT_BITS:0];
  localparam logic [CNT_BITS:0]   D30     = DUTY_30[CNT_BITS:0];
  localparam logic [CNT_BITS:0]   D50     = DUTY_50[CNT_BITS:0];
  localparam logic [CNT_BITS:0]   D100    = DUTY_100[CNT_BITS:0];
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [2:0]          lvl_s;
  logic [CNT_BITS:0]   target;
  logic                illegal;
  logic                boundary;

  logic [CNT_BITS-1:0] cnt_q,   cnt_d;
  logic [CNT_BITS:0]   duty_q,  duty_d;
  state_e              state_q, state_d;
  logic                pwm_q,   pwm_d;
  logic                fault_q, fault_d;

  sync2 #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({lvl_100, lvl_50, lvl_30}),
    .q     (lvl_s)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target  = '0;
    illegal = 1'b0;
    case (lvl_s)
      3'b000:  target  = '0;
      3'b001:  target  = D30;
      3'b010:  target  = D50;
      3'b100:  target  = D100;
      default: illegal = 1'b1;
    endcase
  end

  assign boundary = ena && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = ena ? cnt_q + 1'b1 : cnt_q;
    duty_d  = duty_q;
    state_d = state_q;

    if (illegal) begin
      // Fault drops the drive immediately instead of waiting for a boundary.
      state_d = ST_FAULT;
      duty_d  = '0;
    end else if (state_q == ST_FAULT) begin
      if (lvl_s == 3'b000) state_d = ST_IDLE;
    end else begin
      if (boundary) begin
        if (duty_q < target)
          duty_d = (target - duty_q > STEP_W) ? duty_q + STEP_W : target;
        else if (duty_q > target)
          duty_d = (duty_q - target > STEP_W) ? duty_q - STEP_W : target;
      end
      if (duty_d != target)  state_d = ST_RAMP;
      else if (target == '0) state_d = ST_IDLE;
      else                   state_d = ST_HOLD;
    end

    fault_d = (state_d == ST_FAULT);
    pwm_d   = ena && (state_q != ST_FAULT) && ({1'b0, cnt_q} < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      state_q <= ST_IDLE;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      state_q <= state_d;
      pwm_q   <= pwm_d;
      fault_q <= fault_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign duty      = duty_q;
  assign fault     = fault_q;
  assign at_target = (duty_q == target) && !fault_q;

endmodule
